// File: rtl/kc705_tx_arb_pkg.sv
// Shared types and encodings for the KC705 TX AXI-Stream packet arbiter.
package kc705_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  localparam logic [1:0] ACTIVE_NONE = 2'b00;
  localparam logic [1:0] ACTIVE_SRC0 = 2'b01;
  localparam logic [1:0] ACTIVE_SRC1 = 2'b10;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/kc705_tx_arb_frame_mon.sv
// Per-source frame monitor: beat counter with oversize detection and a
// wrapping completed-frame counter.
module kc705_tx_arb_frame_mon
  import kc705_tx_arb_pkg::*;
#(
  parameter logic [15:0] MAX_PKT_BEATS = 16'd1518
) (
  input  logic        axi_tclk,
  input  logic        axi_tresetn,
  input  logic        start,
  input  logic        beat,
  input  logic        last,
  output logic [15:0] pkt_count,
  output logic        oversize_err
);

  logic [15:0] beat_count;

  // beat_count holds beats already accepted, so it equals MAX-1 on the
  // MAX-th beat; it then parks at MAX so the pulse cannot repeat.
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      beat_count   <= '0;
      pkt_count    <= '0;
      oversize_err <= 1'b0;
    end else begin
      oversize_err <= beat && !last && (beat_count == (MAX_PKT_BEATS - 16'd1));
      if (start)
        beat_count <= '0;
      else if (beat && (beat_count != MAX_PKT_BEATS))
        beat_count <= beat_count + 16'd1;
      if (beat && last)
        pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: rtl/kc705_ethernet_rgmii_axi_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the TX AXI-Stream between two sources.
// Optional inter-frame gap enabled by defining KC705_TX_ARB_IFG_EN.
module kc705_ethernet_rgmii_axi_tx_arbiter
  import kc705_tx_arb_pkg::*;
#(
  parameter int          DATA_WIDTH    = 8,
  parameter logic [15:0] MAX_PKT_BEATS = 16'd1518
`ifdef KC705_TX_ARB_IFG_EN
  ,
  parameter int          IFG_CYCLES    = 12
`endif
) (
  input  logic                  axi_tclk,
  input  logic                  axi_tresetn,
  input  logic                  enable_src0,
  input  logic                  enable_src1,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] tx_axis_tdata,
  output logic                  tx_axis_tvalid,
  output logic                  tx_axis_tlast,
  input  logic                  tx_axis_tready,
  output logic [1:0]            active_src,
  output logic [15:0]           pkt_count0,
  output logic [15:0]           pkt_count1,
  output logic                  oversize_err
);

  arb_state_e state, state_next;
  logic       last_grant, last_grant_next;
  logic       req0, req1;
  logic       start0, start1, beat0, beat1;
  logic       ovf0, ovf1;
`ifdef KC705_TX_ARB_IFG_EN
  logic [15:0] gap_count, gap_count_next;
`endif

  assign req0 = s0_axis_tvalid & enable_src0;
  assign req1 = s1_axis_tvalid & enable_src1;

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state      <= IDLE;
      last_grant <= SRC1;
`ifdef KC705_TX_ARB_IFG_EN
      gap_count  <= '0;
`endif
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
`ifdef KC705_TX_ARB_IFG_EN
      gap_count  <= gap_count_next;
`endif
    end
  end

  // Grants are only decided from IDLE, so a frame always runs to its tlast.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
`ifdef KC705_TX_ARB_IFG_EN
    gap_count_next  = gap_count;
`endif
    s0_axis_tready  = 1'b0;
    s1_axis_tready  = 1'b0;
    tx_axis_tdata   = '0;
    tx_axis_tvalid  = 1'b0;
    tx_axis_tlast   = 1'b0;
    active_src      = ACTIVE_NONE;
    start0          = 1'b0;
    start1          = 1'b0;
    beat0           = 1'b0;
    beat1           = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || (last_grant == SRC1))) begin
          state_next      = GRANT0;
          last_grant_next = SRC0;
          start0          = 1'b1;
        end else if (req1) begin
          state_next      = GRANT1;
          last_grant_next = SRC1;
          start1          = 1'b1;
        end
      end
      GRANT0: begin
        tx_axis_tdata  = s0_axis_tdata;
        tx_axis_tvalid = s0_axis_tvalid;
        tx_axis_tlast  = s0_axis_tlast;
        s0_axis_tready = tx_axis_tready;
        active_src     = ACTIVE_SRC0;
        beat0          = s0_axis_tvalid & tx_axis_tready;
      end
      GRANT1: begin
        tx_axis_tdata  = s1_axis_tdata;
        tx_axis_tvalid = s1_axis_tvalid;
        tx_axis_tlast  = s1_axis_tlast;
        s1_axis_tready = tx_axis_tready;
        active_src     = ACTIVE_SRC1;
        beat1          = s1_axis_tvalid & tx_axis_tready;
      end
      GAP: begin
`ifdef KC705_TX_ARB_IFG_EN
        if (gap_count <= 16'd1)
          state_next = IDLE;
        else
          gap_count_next = gap_count - 16'd1;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase

    if ((beat0 && s0_axis_tlast) || (beat1 && s1_axis_tlast)) begin
`ifdef KC705_TX_ARB_IFG_EN
      state_next     = GAP;
      gap_count_next = 16'(IFG_CYCLES);
`else
      state_next     = IDLE;
`endif
    end
  end

  kc705_tx_arb_frame_mon #(.MAX_PKT_BEATS(MAX_PKT_BEATS)) u_mon0 (
    .axi_tclk     (axi_tclk),
    .axi_tresetn  (axi_tresetn),
    .start        (start0),
    .beat         (beat0),
    .last         (s0_axis_tlast),
    .pkt_count    (pkt_count0),
    .oversize_err (ovf0)
  );

  kc705_tx_arb_frame_mon #(.MAX_PKT_BEATS(MAX_PKT_BEATS)) u_mon1 (
    .axi_tclk     (axi_tclk),
    .axi_tresetn  (axi_tresetn),
    .start        (start1),
    .beat         (beat1),
    .last         (s1_axis_tlast),
    .pkt_count    (pkt_count1),
    .oversize_err (ovf1)
  );

  assign oversize_err = ovf0 | ovf1;

endmodule

// File: tb/tb_kc705_ethernet_rgmii_axi_tx_arbiter.sv
// Self-checking bench for the TX arbiter: queue-driven sources, a rule-level
// arbitration model with per-cycle comparison, and literal frame-level checks.
module tb_kc705_ethernet_rgmii_axi_tx_arbiter;

  localparam int MAXB = 1518;
`ifdef KC705_TX_ARB_IFG_EN
  localparam int IFG = 12;
`else
  localparam int IFG = 0;
`endif
  localparam int GAP_EXPECT = (IFG > 0) ? IFG + 1 : 1;

  logic       axi_tclk = 1'b0;
  logic       axi_tresetn = 1'b0;
  logic       enable_src0 = 1'b1, enable_src1 = 1'b1;
  logic [7:0] s0_axis_tdata, s1_axis_tdata, tx_axis_tdata;
  logic       s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic       s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic       tx_axis_tvalid, tx_axis_tlast, tx_axis_tready;
  logic [1:0] active_src;
  logic [15:0] pkt_count0, pkt_count1;
  logic       oversize_err;

  kc705_ethernet_rgmii_axi_tx_arbiter #(.DATA_WIDTH(8), .MAX_PKT_BEATS(16'd1518)) dut (
    .axi_tclk(axi_tclk), .axi_tresetn(axi_tresetn),
    .enable_src0(enable_src0), .enable_src1(enable_src1),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tlast(tx_axis_tlast), .tx_axis_tready(tx_axis_tready),
    .active_src(active_src), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1),
    .oversize_err(oversize_err)
  );

  always #5 axi_tclk = ~axi_tclk;

  typedef struct packed { logic last; logic [7:0] data; } beat_t;
  beat_t drv0[$], drv1[$], exp0[$], exp1[$];
  logic  rdy_pat[$];
  logic  rdy_idle = 1'b1;

  int checks = 0, errors = 0, cyc = 0;
  int gstart[$], gend[$], grant_log[$];
  int ovf_seen = 0, acc1_beats = 0;
  bit in_frame = 0;
  logic [1:0] prev_active = 2'b00;

  // Model state: owner 0 = nobody, 1 = src0, 2 = src1; m_last = source last granted
  int m_owner = 0, m_last = 1, m_gap = 0, m_beats = 0, m_cnt0 = 0, m_cnt1 = 0;
  bit m_ovf = 0;
  logic       exv, exl, exr0, exr1, hs, lst, r0, r1;
  logic [7:0] exd;
  logic [1:0] exa;
  beat_t      eb;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge axi_tclk);
    #3;
  endtask

  task automatic applyStimulus(input int src, input int len, input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + 8'(i);
      b.last = (i == len - 1);
      if (src == 0) begin drv0.push_back(b); exp0.push_back(b); end
      else begin drv1.push_back(b); exp1.push_back(b); end
    end
  endtask

  task automatic clearLogs();
    gstart.delete(); gend.delete(); grant_log.delete();
    ovf_seen = 0; acc1_beats = 0;
  endtask

  task automatic applyReset();
    axi_tresetn = 1'b0;
    drv0.delete(); drv1.delete(); exp0.delete(); exp1.delete(); rdy_pat.delete();
    enable_src0 = 1'b1; enable_src1 = 1'b1; rdy_idle = 1'b1;
    waitCycles(3);
    axi_tresetn = 1'b1;
    clearLogs();
    waitCycles(1);
  endtask

  task automatic waitFrames(input int n, input int budget);
    int k = 0;
    while (gend.size() < n && k < budget) begin waitCycles(1); k++; end
    checkOutput("frames_done", gend.size(), n);
  endtask

  // Source driver: pops a beat after each observed handshake, presents the queue head.
  initial begin
    logic a0, a1;
    s0_axis_tvalid = 0; s0_axis_tdata = 0; s0_axis_tlast = 0;
    s1_axis_tvalid = 0; s1_axis_tdata = 0; s1_axis_tlast = 0;
    tx_axis_tready = 1'b1;
    forever begin
      @(negedge axi_tclk);
      a0 = s0_axis_tvalid & s0_axis_tready;
      a1 = s1_axis_tvalid & s1_axis_tready;
      @(posedge axi_tclk);
      #2;
      if (a0 && drv0.size() > 0) void'(drv0.pop_front());
      if (a1 && drv1.size() > 0) void'(drv1.pop_front());
      s0_axis_tvalid = drv0.size() > 0;
      s0_axis_tdata  = (drv0.size() > 0) ? drv0[0].data : 8'h00;
      s0_axis_tlast  = (drv0.size() > 0) ? drv0[0].last : 1'b0;
      s1_axis_tvalid = drv1.size() > 0;
      s1_axis_tdata  = (drv1.size() > 0) ? drv1[0].data : 8'h00;
      s1_axis_tlast  = (drv1.size() > 0) ? drv1[0].last : 1'b0;
      tx_axis_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : rdy_idle;
    end
  end

  // Compare process: expected outputs from the model, scoreboard on beats, then model step.
  initial forever begin
    @(negedge axi_tclk);
    cyc++;
    if (!axi_tresetn) begin
      checkOutput("rst_tx_tvalid", tx_axis_tvalid, 0);
      checkOutput("rst_tready", {s0_axis_tready, s1_axis_tready}, 0);
      checkOutput("rst_active_src", active_src, 0);
      checkOutput("rst_counts", {pkt_count0, pkt_count1, 15'd0, oversize_err}, 0);
      m_owner = 0; m_last = 1; m_gap = 0; m_beats = 0; m_cnt0 = 0; m_cnt1 = 0; m_ovf = 0;
      prev_active = 2'b00; in_frame = 0;
    end else begin
      exv = 0; exl = 0; exd = 0; exr0 = 0; exr1 = 0; exa = 2'b00;
      if (m_owner == 1) begin
        exv = s0_axis_tvalid; exl = s0_axis_tlast; exd = s0_axis_tdata; exr0 = tx_axis_tready; exa = 2'b01;
      end else if (m_owner == 2) begin
        exv = s1_axis_tvalid; exl = s1_axis_tlast; exd = s1_axis_tdata; exr1 = tx_axis_tready; exa = 2'b10;
      end
      checkOutput("tx_tvalid", tx_axis_tvalid, exv);
      checkOutput("tx_tlast", tx_axis_tlast, exl);
      checkOutput("tx_tdata", tx_axis_tdata, exd);
      checkOutput("s0_tready", s0_axis_tready, exr0);
      checkOutput("s1_tready", s1_axis_tready, exr1);
      checkOutput("active_src", active_src, exa);
      checkOutput("pkt_count0", pkt_count0, m_cnt0);
      checkOutput("pkt_count1", pkt_count1, m_cnt1);
      checkOutput("oversize_err", oversize_err, m_ovf);

      if (tx_axis_tvalid && tx_axis_tready) begin
        if (m_owner == 0) checkOutput("unexpected_beat", tx_axis_tvalid, 0);
        else if ((m_owner == 1 ? exp0.size() : exp1.size()) == 0)
          checkOutput("beat_expected", tx_axis_tvalid, 0);
        else begin
          eb = (m_owner == 1) ? exp0.pop_front() : exp1.pop_front();
          checkOutput("sb_data", tx_axis_tdata, eb.data);
          checkOutput("sb_last", tx_axis_tlast, eb.last);
        end
        if (!in_frame) begin gstart.push_back(cyc); in_frame = 1; end
        if (tx_axis_tlast) begin gend.push_back(cyc); in_frame = 0; end
        if (active_src == 2'b10) acc1_beats++;
      end
      if (oversize_err) ovf_seen++;
      if (active_src != prev_active && active_src != 2'b00) grant_log.push_back(int'(active_src));
      prev_active = active_src;

      m_ovf = 0;
      if (m_owner == 0) begin
        if (m_gap > 0) m_gap--;
        else begin
          r0 = s0_axis_tvalid & enable_src0;
          r1 = s1_axis_tvalid & enable_src1;
          if (r0 && (!r1 || m_last == 1)) begin m_owner = 1; m_last = 0; m_beats = 0; end
          else if (r1) begin m_owner = 2; m_last = 1; m_beats = 0; end
        end
      end else begin
        hs  = ((m_owner == 1) ? s0_axis_tvalid : s1_axis_tvalid) & tx_axis_tready;
        lst = (m_owner == 1) ? s0_axis_tlast : s1_axis_tlast;
        if (hs) begin
          m_beats++;
          if (m_beats == MAXB && !lst) m_ovf = 1;
          if (lst) begin
            if (m_owner == 1) m_cnt0 = (m_cnt0 + 1) & 16'hFFFF;
            else m_cnt1 = (m_cnt1 + 1) & 16'hFFFF;
            m_owner = 0;
            m_gap = IFG;
          end
        end
      end
    end
  end

  initial begin
    int k;
    waitCycles(2);
    applyReset();

    $display("[TB] single src0 frame of 64 beats");
    applyStimulus(0, 64, 8'h00);
    waitFrames(1, 200);
    waitCycles(2);
    checkOutput("t1_pkt_count0", pkt_count0, 16'd1);
    checkOutput("t1_active_idle", active_src, 2'b00);
    checkOutput("t1_frame_len", gend[0] - gstart[0], 63);

    $display("[TB] both sources, alternating 16-beat frames");
    applyReset();
    for (int f = 0; f < 4; f++) begin
      applyStimulus(0, 16, 8'h40 + 8'(f * 16));
      applyStimulus(1, 16, 8'h80 + 8'(f * 16));
    end
    waitFrames(8, 800);
    waitCycles(2);
    checkOutput("t2_pkt_count0", pkt_count0, 16'd4);
    checkOutput("t2_pkt_count1", pkt_count1, 16'd4);
    checkOutput("t2_grants", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      checkOutput("t2_grant_order", grant_log[i], (i % 2 == 0) ? 1 : 2);
    for (int i = 0; i + 1 < gend.size() && i + 1 < gstart.size(); i++) begin
      checkOutput("t2_frame_len", gend[i] - gstart[i], 15);
      checkOutput("t2_gap", gstart[i+1] - gend[i] - 1, GAP_EXPECT);
    end

    $display("[TB] src1 frame with toggling tx_tready");
    applyReset();
    for (int r = 0; r < 4; r++) begin
      rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0);
      rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(1);
    end
    applyStimulus(1, 8, 8'hC0);
    waitFrames(1, 100);
    waitCycles(2);
    checkOutput("t3_beats", acc1_beats, 8);
    checkOutput("t3_pkt_count1", pkt_count1, 16'd1);

    $display("[TB] enable_src1 dropped mid-frame");
    applyReset();
    applyStimulus(1, 20, 8'h10);
    applyStimulus(1, 10, 8'h90);
    k = 0;
    while (acc1_beats < 5 && k < 100) begin waitCycles(1); k++; end
    checkOutput("t4_reached_beat5", acc1_beats >= 5, 1);
    enable_src1 = 1'b0;
    applyStimulus(0, 8, 8'h20);
    applyStimulus(0, 8, 8'h30);
    waitFrames(3, 300);
    waitCycles(30);
    checkOutput("t4_src1_beats", acc1_beats, 20);
    checkOutput("t4_pkt_count1", pkt_count1, 16'd1);
    checkOutput("t4_pkt_count0", pkt_count0, 16'd2);
    checkOutput("t4_frames", gend.size(), 3);
    checkOutput("t4_grant_log", grant_log.size(), 3);
    if (grant_log.size() == 3)
      checkOutput("t4_grant_order", {grant_log[0][1:0], grant_log[1][1:0], grant_log[2][1:0]}, 6'b10_01_01);

    $display("[TB] oversize src0 frame of 1600 beats");
    applyReset();
    applyStimulus(0, 1600, 8'h00);
    waitFrames(1, 2000);
    waitCycles(2);
    checkOutput("t5_ovf_pulses", ovf_seen, 1);
    checkOutput("t5_pkt_count0", pkt_count0, 16'd1);
    checkOutput("t5_frame_len", gend[0] - gstart[0], 1599);

    $display("[TB] asynchronous reset mid-frame");
    applyReset();
    applyStimulus(1, 30, 8'h55);
    waitCycles(10);
    checkOutput("t6_mid_frame", active_src, 2'b10);
    axi_tresetn = 1'b0;
    #1;
    checkOutput("t6_rst_tvalid", tx_axis_tvalid, 0);
    checkOutput("t6_rst_tdata", tx_axis_tdata, 0);
    checkOutput("t6_rst_s1_tready", s1_axis_tready, 0);
    checkOutput("t6_rst_active", active_src, 0);
    applyReset();
    applyStimulus(0, 4, 8'hA0);
    applyStimulus(1, 4, 8'hB0);
    waitFrames(2, 100);
    checkOutput("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : 0, 1);
    checkOutput("t6_pkt_count1", pkt_count1, 16'd1);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
